// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// rxd is brought into the clk domain through a two-flop synchroniser; a start
// bit is confirmed at its middle, then each data bit and the stop bit are
// sampled one full bit period apart, i.e. at mid-bit. Received bytes are
// offered on a valid/ack handshake with framing-error and overrun pulses.
module uart_rx #(
    parameter int BIT_CLK = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       framing_err,
    output logic       overrun
);

    localparam logic [15:0] BIT_LAST  = 16'(BIT_CLK - 1);
    localparam logic [15:0] HALF_LAST = 16'((BIT_CLK / 2) - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t      state_r,  state_s;
    logic [15:0] count_r,  count_s;
    logic [2:0]  index_r,  index_s;
    logic [7:0]  shift_r,  shift_s;
    logic        sync1_r,  sync2_r;
    logic        rxd_s;
    logic        deliver_s;
    logic        ferr_s;
    logic        ovr_s;
    logic [7:0]  data_s;
    logic        valid_s;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        framing_err_r;
    logic        overrun_r;

    assign rxd_s = sync2_r;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
        end
    end

    // Receive FSM next-state logic: bit timing, data capture, stop check.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        index_s   = index_r;
        shift_s   = shift_r;
        deliver_s = 1'b0;
        ferr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (rxd_s == 1'b0) begin
                    state_s = START;
                    count_s = 16'd0;
                end else begin
                    count_s = 16'd0;
                end
            end
            START: begin
                if (count_r == HALF_LAST) begin
                    count_s = 16'd0;
                    index_s = 3'd0;
                    if (rxd_s == 1'b0) begin
                        state_s = DATA;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_s = IDLE;
                    end
                end else begin
                    count_s = count_r + 16'd1;
                end
            end
            DATA: begin
                if (count_r == BIT_LAST) begin
                    shift_s[index_r] = rxd_s;
                    count_s          = 16'd0;
                    if (index_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        index_s = index_r + 3'd1;
                    end
                end else begin
                    count_s = count_r + 16'd1;
                end
            end
            STOP: begin
                if (count_r == BIT_LAST) begin
                    count_s = 16'd0;
                    if (rxd_s == 1'b1) begin
                        deliver_s = 1'b1;
                        state_s   = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = WAIT_HIGH;
                    end
                end else begin
                    count_s = count_r + 16'd1;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not look like a new start bit.
                if (rxd_s == 1'b1) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            default: begin
                state_s = IDLE;
                count_s = 16'd0;
                index_s = 3'd0;
            end
        endcase
    end

    // Handshake next-state: accept, drop with overrun, or clear on ack.
    always_comb begin
        data_s  = rx_data_r;
        valid_s = rx_valid_r;
        ovr_s   = 1'b0;
        if (deliver_s) begin
            if (!rx_valid_r || rx_ack) begin
                data_s  = shift_r;
                valid_s = 1'b1;
            end else begin
                ovr_s = 1'b1;
            end
        end else if (rx_ack && rx_valid_r) begin
            valid_s = 1'b0;
        end else begin
            valid_s = rx_valid_r;
        end
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            count_r       <= 16'd0;
            index_r       <= 3'd0;
            shift_r       <= 8'd0;
            rx_data_r     <= 8'd0;
            rx_valid_r    <= 1'b0;
            framing_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            index_r       <= index_s;
            shift_r       <= shift_s;
            rx_data_r     <= data_s;
            rx_valid_r    <= valid_s;
            framing_err_r <= ferr_s;
            overrun_r     <= ovr_s;
        end
    end

    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign framing_err = framing_err_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are bit-banged onto
// rxd; a monitor records every byte offered (rising edge of rx_valid) and
// counts error pulses; the expected bytes and pulse counts come from what
// was sent and the handshake rules.
module tb_uart_rx;

    localparam int BCLK = 87;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       framing_err;
    logic       overrun;

    int n_cmp;
    int n_err;

    // Monitor results (written only by the monitor process).
    logic [7:0] got [0:255];
    int         got_n;
    int         ferr_cnt;
    int         ovr_cnt;
    int         both_cnt;
    logic       valid_prev;

    // Reference expectations (written only by the main process).
    logic [7:0] exp_q [$];
    int         rd_idx;

    uart_rx #(.BIT_CLK(BCLK)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: record newly offered bytes and error pulses away from the edge.
    initial begin
        got_n      = 0;
        ferr_cnt   = 0;
        ovr_cnt    = 0;
        both_cnt   = 0;
        valid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid && !valid_prev && got_n < 256) begin
                got[got_n] = rx_data;
                got_n      = got_n + 1;
            end
            if (framing_err) ferr_cnt = ferr_cnt + 1;
            if (overrun)     ovr_cnt  = ovr_cnt + 1;
            if (framing_err && overrun) both_cnt = both_cnt + 1;
            valid_prev = rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    // One 8N1 frame, LSB first, bclk cycles per bit; line left at stop level.
    task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (bclk) tick();
        end
    endtask

    // Compare bytes offered since the last call with the expected list.
    task automatic verify_rx(input string tag);
        int n;
        n = got_n - rd_idx;
        check({tag, " byte count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check({tag, " byte"}, {24'd0, got[rd_idx + i]}, {24'd0, exp_q[i]});
        end
        rd_idx = got_n;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         f0;
        int         o0;
        int         lat;
        int         rate;
        logic [7:0] fixed [4];

        n_cmp  = 0;
        n_err  = 0;
        rd_idx = 0;
        rst    = 1'b1;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        fixed[0] = 8'hA5; fixed[1] = 8'h00; fixed[2] = 8'hFF; fixed[3] = 8'h5A;

        repeat (3) tick();
        @(negedge clk);
        check("reset rx_data", {24'd0, rx_data}, 32'd0);
        check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset framing_err", {31'd0, framing_err}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        tick();
        rst = 1'b0;
        idle(20);

        // Loopback: fixed then random bytes, back to back, ack held high.
        rx_ack = 1'b1;
        f0 = ferr_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 10; i++) begin
            b = (i < 4) ? fixed[i] : 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, BCLK, 1'b1);
        end
        idle(50);
        verify_rx("loopback");
        check("loopback framing_err", ferr_cnt - f0, 0);
        check("loopback overrun", ovr_cnt - o0, 0);

        // Glitch shorter than half a bit, then a real frame with latency check.
        f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (20) tick();
        idle(200);
        verify_rx("glitch");
        check("glitch framing_err", ferr_cnt - f0, 0);
        exp_q.push_back(8'h3C);
        lat = 0;
        fork
            send_frame(8'h3C, BCLK, 1'b1);
            begin
                for (int c = 1; c <= 1200 && lat == 0; c++) begin
                    @(negedge clk);
                    if (rx_valid) lat = c;
                end
            end
        join
        idle(20);
        check("latency in window", {31'd0, (lat >= 827 && lat <= 831)}, 32'd1);
        verify_rx("after glitch");

        // Framing error followed by a break, then recovery.
        f0 = ferr_cnt;
        send_frame(8'h81, BCLK, 1'b0);
        repeat (5 * BCLK) tick();
        check("ferr pulse count", ferr_cnt - f0, 1);
        check("ferr rx_valid", {31'd0, rx_valid}, 32'd0);
        verify_rx("ferr no byte");
        idle(100);
        exp_q.push_back(8'h42);
        send_frame(8'h42, BCLK, 1'b1);
        idle(20);
        verify_rx("after ferr");
        check("ferr no retrigger", ferr_cnt - f0, 1);

        // Overrun: two bytes without ack, then ack clears.
        rx_ack = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, BCLK, 1'b1);
        idle(20);
        check("ovr first valid", {31'd0, rx_valid}, 32'd1);
        check("ovr first data", {24'd0, rx_data}, 32'h11);
        send_frame(8'h22, BCLK, 1'b1);
        idle(20);
        check("ovr pulse count", ovr_cnt - o0, 1);
        check("ovr data kept", {24'd0, rx_data}, 32'h11);
        check("ovr valid kept", {31'd0, rx_valid}, 32'd1);
        verify_rx("overrun");
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        @(negedge clk);
        check("ack clears valid", {31'd0, rx_valid}, 32'd0);
        tick();

        // Ack in the stop-sample cycle while a byte is pending.
        exp_q.push_back(8'h66);
        send_frame(8'h66, BCLK, 1'b1);
        idle(20);
        verify_rx("pending");
        o0 = ovr_cnt;
        fork
            send_frame(8'h77, BCLK, 1'b1);
            begin
                repeat (2 + 1 + BCLK / 2 + 9 * BCLK - 1) tick();
                rx_ack = 1'b1;
                tick();
                rx_ack = 1'b0;
            end
        join
        idle(20);
        check("collision data", {24'd0, rx_data}, 32'h77);
        check("collision valid", {31'd0, rx_valid}, 32'd1);
        check("collision overrun", ovr_cnt - o0, 0);

        // Baud tolerance: 0xC3 at both extremes, then random rates.
        rx_ack = 1'b1;
        tick();
        rd_idx = got_n;
        f0 = ferr_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 6; i++) begin
            rate = (i == 0) ? 84 : (i == 1) ? 90 : int'($urandom_range(84, 90));
            b    = (i < 2) ? 8'hC3 : 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, rate, 1'b1);
            idle(int'($urandom_range(5, 60)));
        end
        verify_rx("baud");
        check("baud errors", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        // Reset during bit 4 of a frame whose upper nibble keeps the line high.
        rx_ack = 1'b0;
        exp_q.push_back(8'h5E);
        send_frame(8'h5E, BCLK, 1'b1);
        idle(20);
        verify_rx("pre-reset");
        f0 = ferr_cnt; o0 = ovr_cnt;
        b = {4'hF, 4'($urandom_range(0, 15))};
        fork
            send_frame(b, BCLK, 1'b1);
            begin
                repeat (5 * BCLK + BCLK / 2) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                @(negedge clk);
                check("mid reset rx_valid", {31'd0, rx_valid}, 32'd0);
                check("mid reset rx_data", {24'd0, rx_data}, 32'd0);
            end
        join
        idle(100);
        verify_rx("abandoned frame");
        check("reset pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        rx_ack = 1'b1;
        exp_q.push_back(8'h99);
        send_frame(8'h99, BCLK, 1'b1);
        idle(20);
        verify_rx("after reset");

        check("ferr and overrun together", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
